// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin front end sharing one start_n/done sequential divider
// among NUM_REQ requesters, with local divide-by-zero answers and a hung-divider timeout.
module div_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DVD_W   = 8,
  parameter int DVS_W   = 9,
  parameter int TIMEOUT = 32,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*DVD_W-1:0] req_dividend,
  input  logic [NUM_REQ*DVS_W-1:0] req_divisor,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IDW-1:0]           resp_id,
  output logic [DVD_W-1:0]         resp_quot,
  output logic [DVS_W-1:0]         resp_rem,
  output logic                     resp_dvz,
  output logic                     resp_tmo,
  output logic                     div_start_n,
  output logic [DVD_W-1:0]         div_dividend,
  output logic [DVS_W-1:0]         div_divisor,
  input  logic                     div_done,
  input  logic                     div_dvz,
  input  logic [DVD_W-1:0]         div_quot,
  input  logic [DVS_W-1:0]         div_rem,
  output logic                     busy
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_SETTLE, S_WAIT, S_RESP} state_t;
  state_t           r_state, w_nxt;
  logic [IDW-1:0]   r_rr, r_id, w_gnt;
  logic [CW-1:0]    r_cnt;
  logic [DVD_W-1:0] r_dvd, r_quot, w_dvd;
  logic [DVS_W-1:0] r_dvs, r_rem, w_dvs;
  logic             r_dvz, r_tmo, r_start_n, w_xfer, w_tmo;
  function automatic logic [IDW-1:0] wrap(input int v);
    return IDW'(v % NUM_REQ);
  endfunction
  // Scan offsets high to low so the requester nearest rr_ptr wins.
  always_comb begin
    w_gnt = r_rr;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[wrap(int'(r_rr) + k)]) w_gnt = wrap(int'(r_rr) + k);
  end
  assign w_xfer    = r_state == S_IDLE && |req_valid && !rst;
  assign req_ready = w_xfer ? NUM_REQ'(1) << w_gnt : '0;
  assign w_dvd     = req_dividend[w_gnt*DVD_W +: DVD_W];
  assign w_dvs     = req_divisor[w_gnt*DVS_W +: DVS_W];
  assign w_tmo     = r_cnt == CW'(TIMEOUT - 1);
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_xfer) w_nxt = w_dvs == '0 ? S_RESP : S_LAUNCH;
      S_LAUNCH: w_nxt = S_SETTLE;
      S_SETTLE: if (r_cnt == CW'(1)) w_nxt = S_WAIT;
      S_WAIT:   if (div_done || div_dvz || w_tmo) w_nxt = S_RESP;
      S_RESP:   if (resp_ready) w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr      <= '0;
      r_id      <= '0;
      r_cnt     <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_dvz     <= 1'b0;
      r_tmo     <= 1'b0;
      r_start_n <= 1'b1;
    end else begin
      r_start_n <= w_nxt != S_LAUNCH;
      // One counter serves both the 2-cycle settle and the done timeout.
      r_cnt <= (w_nxt == r_state && (r_state == S_SETTLE || r_state == S_WAIT)) ? r_cnt + 1'b1 : '0;
      if (w_xfer) begin
        r_id   <= w_gnt;
        r_rr   <= wrap(int'(w_gnt) + 1);
        r_dvd  <= w_dvd;
        r_dvs  <= w_dvs;
        r_quot <= '0;
        r_rem  <= '0;
        r_dvz  <= w_dvs == '0;
        r_tmo  <= 1'b0;
      end
      if (r_state == S_WAIT) begin
        if (div_done) begin
          r_quot <= div_quot;
          r_rem  <= div_rem;
        end else if (div_dvz) r_dvz <= 1'b1;
        else if (w_tmo) r_tmo <= 1'b1;
      end
    end
  end
  assign resp_valid   = r_state == S_RESP;
  assign resp_id      = r_id;
  assign resp_quot    = r_quot;
  assign resp_rem     = r_rem;
  assign resp_dvz     = r_dvz;
  assign resp_tmo     = r_tmo;
  assign div_start_n  = r_start_n;
  assign div_dividend = r_dvd;
  assign div_divisor  = r_dvs;
  assign busy         = r_state != S_IDLE;
endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: transaction-level reference model checked every cycle, a behavioural
// divider with normal/hang/dvz modes, and literal expectations for the directed scenarios.
module tb_div_share_arbiter;
  localparam int N = 4, DW = 8, SW = 9, TMO = 32;
  logic clk = 0, rst;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*DW-1:0] req_dividend = '0;
  logic [N*SW-1:0] req_divisor = '0;
  logic resp_valid, resp_ready = 1'b1;
  logic [1:0] resp_id;
  logic [DW-1:0] resp_quot, div_dividend, div_quot;
  logic [SW-1:0] resp_rem, div_divisor, div_rem;
  logic resp_dvz, resp_tmo, div_start_n, div_done, div_dvz, busy;
  div_share_arbiter #(.NUM_REQ(N), .DVD_W(DW), .DVS_W(SW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_quot(resp_quot), .resp_rem(resp_rem), .resp_dvz(resp_dvz), .resp_tmo(resp_tmo),
    .div_start_n(div_start_n), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_done(div_done), .div_dvz(div_dvz), .div_quot(div_quot), .div_rem(div_rem),
    .busy(busy));
  always #5 clk = ~clk;
  // Divider: outputs lag start by 2 clocks, done returns 10 clocks after start is sampled.
  // dmode 0 = normal, 1 = hangs (done stays low), 2 = raises DVZ instead of done.
  int dcnt = 0, dmode = 0;
  logic stuck = 1'b0;
  logic [DW-1:0] dq = '0;
  logic [SW-1:0] dr = '0;
  always @(posedge clk)
    if (div_start_n === 1'b0) begin
      dcnt  <= 10;
      stuck <= dmode != 0;
      dq    <= DW'(div_dividend / div_divisor);
      dr    <= div_dividend % div_divisor;
    end else if (dcnt > 0) dcnt <= dcnt - 1;
  assign div_done = dcnt == 0 && !stuck;
  assign div_dvz  = dcnt == 0 && stuck && dmode == 2;
  assign div_quot = dq;
  assign div_rem  = dr;
  int n_chk = 0, n_pass = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask
  // Reference model: one transaction in flight, expected outcome and response cycle
  // decided at accept time from operands and divider mode.
  bit m_busy = 0, m_nz, m_dvz, m_tmo, found, rv;
  int m_rr = 0, m_t, m_due, m_id, m_dvd, m_dvs, m_q, m_r, g;
  logic [N-1:0] er;
  int n_start = 0, n_resp = 0, n_grant = 0, glog[64];
  int l_id, l_q, l_r, l_dvz, l_tmo, l_lat;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_start_n", div_start_n, 1);
      chk("rst_busy", busy, 0);
      chk("rst_resp_data", {resp_id, resp_quot, resp_rem, resp_dvz, resp_tmo}, 0);
      chk("rst_div_ops", {div_dividend, div_divisor}, 0);
      m_busy = 0;
      m_rr = 0;
    end else begin
      if (!div_start_n) n_start++;
      found = 0;
      g = 0;
      for (int k = 0; k < N; k++)
        if (!found && req_valid[(m_rr + k) % N]) begin
          found = 1;
          g = (m_rr + k) % N;
        end
      er = '0;
      if (!m_busy && found) er[g] = 1'b1;
      rv = m_busy && cyc >= m_due;
      chk("req_ready", req_ready, er);
      chk("start_n", div_start_n, !(m_busy && m_nz && cyc == m_t + 1));
      chk("busy", busy, m_busy);
      chk("resp_valid", resp_valid, rv);
      if (rv) begin
        chk("resp_id", resp_id, m_id);
        chk("resp_quot", resp_quot, m_q);
        chk("resp_rem", resp_rem, m_r);
        chk("resp_dvz", resp_dvz, m_dvz);
        chk("resp_tmo", resp_tmo, m_tmo);
      end
      if (m_busy && m_nz) begin
        chk("div_dividend", div_dividend, m_dvd);
        chk("div_divisor", div_divisor, m_dvs);
      end
      if (!m_busy && found) begin
        m_busy = 1;
        m_t = cyc;
        m_id = g;
        m_dvd = int'(req_dividend[g*DW +: DW]);
        m_dvs = int'(req_divisor[g*SW +: SW]);
        m_nz = m_dvs != 0;
        m_rr = (g + 1) % N;
        glog[n_grant++] = g;
        m_q = 0; m_r = 0; m_dvz = 0; m_tmo = 0;
        if (!m_nz) begin m_dvz = 1; m_due = m_t + 1; end
        else if (dmode == 1) begin m_tmo = 1; m_due = m_t + 4 + TMO; end
        else if (dmode == 2) begin m_dvz = 1; m_due = m_t + 13; end
        else begin m_q = m_dvd / m_dvs; m_r = m_dvd % m_dvs; m_due = m_t + 13; end
      end else if (rv && resp_ready) begin
        m_busy = 0;
        n_resp++;
        l_id = resp_id; l_q = resp_quot; l_r = resp_rem;
        l_dvz = resp_dvz; l_tmo = resp_tmo; l_lat = cyc - m_t;
      end
    end
  end
  bit hold = 0;
  logic [N-1:0] acc;
  task automatic step();
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    if (!hold) req_valid = req_valid & ~acc;
  endtask
  task automatic set_op(input int i, input int dvd, input int dvs);
    req_dividend[i*DW +: DW] = DW'(dvd);
    req_divisor[i*SW +: SW]  = SW'(dvs);
  endtask
  task automatic one(input int i, input int budget);
    int r0;
    r0 = n_resp;
    req_valid[i] = 1'b1;
    for (int c = 0; c < budget && n_resp == r0; c++) step();
    chk("resp_arrived", n_resp - r0, 1);
  endtask
  int s0, r0, g0;
  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // all four valid continuously: strict rotation from rr_ptr=0
    set_op(0, 200, 7); set_op(1, 255, 16); set_op(2, 100, 3); set_op(3, 9, 9);
    hold = 1;
    req_valid = 4'hF;
    for (int c = 0; c < 100 && n_grant < 5; c++) step();
    hold = 0;
    req_valid = '0;
    for (int c = 0; c < 40 && n_resp < 5; c++) step();
    chk("t2_resps", n_resp, 5);
    chk("t2_g0", glog[0], 0); chk("t2_g1", glog[1], 1); chk("t2_g2", glog[2], 2);
    chk("t2_g3", glog[3], 3); chk("t2_g4", glog[4], 0);
    chk("t2_starts", n_start, 5);
    // single request 200/7
    s0 = n_start;
    set_op(0, 200, 7);
    one(0, 40);
    chk("t1_id", l_id, 0); chk("t1_quot", l_q, 28); chk("t1_rem", l_r, 4);
    chk("t1_dvz", l_dvz, 0); chk("t1_tmo", l_tmo, 0); chk("t1_lat", l_lat, 13);
    chk("t1_starts", n_start - s0, 1);
    // zero divisor answered locally
    s0 = n_start;
    set_op(2, 55, 0);
    one(2, 10);
    chk("t3_id", l_id, 2); chk("t3_dvz", l_dvz, 1); chk("t3_quot", l_q, 0);
    chk("t3_rem", l_r, 0); chk("t3_lat", l_lat, 1); chk("t3_starts", n_start - s0, 0);
    // hung divider -> timeout
    dmode = 1;
    set_op(1, 50, 5);
    one(1, 60);
    chk("t4_tmo", l_tmo, 1); chk("t4_dvz", l_dvz, 0); chk("t4_quot", l_q, 0);
    chk("t4_lat", l_lat, 4 + TMO);
    // divider reports DVZ
    dmode = 2;
    set_op(3, 10, 3);
    one(3, 40);
    chk("dvz_flag", l_dvz, 1); chk("dvz_tmo", l_tmo, 0); chk("dvz_lat", l_lat, 13);
    dmode = 0;
    // consumer stalls with response pending and other requesters waiting
    resp_ready = 1'b0;
    r0 = n_resp;
    set_op(1, 77, 10);
    req_valid = 4'b0010;
    for (int c = 0; c < 40 && !resp_valid; c++) step();
    req_valid = req_valid | 4'b1001;
    s0 = n_start;
    g0 = n_grant;
    repeat (10) step();
    chk("t5_starts", n_start - s0, 0);
    chk("t5_grants", n_grant - g0, 0);
    chk("t5_valid", resp_valid, 1);
    chk("t5_quot", resp_quot, 7);
    chk("t5_rem", resp_rem, 7);
    resp_ready = 1'b1;
    for (int c = 0; c < 60 && n_resp < r0 + 3; c++) step();
    chk("t5_resps", n_resp - r0, 3);
    chk("t5_g_next0", glog[g0], 3);
    chk("t5_g_next1", glog[g0 + 1], 0);
    // reset in WAIT_DONE drops the request; rotation restarts at 0
    set_op(2, 90, 4);
    req_valid = 4'b0100;
    repeat (8) step();
    chk("t6_busy", busy, 1);
    r0 = n_resp;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("t6_no_resp", n_resp - r0, 0);
    g0 = n_grant;
    set_op(1, 20, 3); set_op(3, 30, 4);
    req_valid = 4'b1010;
    for (int c = 0; c < 60 && n_resp < r0 + 2; c++) step();
    chk("t6_resps", n_resp - r0, 2);
    chk("t6_g0", glog[g0], 1);
    chk("t6_g1", glog[g0 + 1], 3);
    chk("t6_last_q", l_q, 7);
    chk("t6_last_r", l_r, 2);
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
